// File: rtl/bmem_pkg.sv
// Shared constants and types for the burst-memory arbiter.
// Line/beat geometry, FSM state and grant encodings.
package bmem_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = 4;
  localparam int CNT_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_BEAT,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  function automatic logic [31:0] line_align(
    input logic [31:0] a
  );
    return a & ~32'h0000_001F;
  endfunction

endpackage

// File: rtl/bmem_arbiter_line_assembler.sv
// Beat counter plus line buffer, shared by read capture
// (insert beat k) and write beat selection (select beat k).
module line_assembler
  import bmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LINE_BITS-1:0] load_data_i,
  input  logic                 ins_i,
  input  logic [BEAT_BITS-1:0] ins_data_i,
  input  logic                 adv_i,
  output logic [LINE_BITS-1:0] fill_o,
  output logic [BEAT_BITS-1:0] beat_o,
  output logic                 last_o
);

  logic [LINE_BITS-1:0] buf_q;
  logic [CNT_W-1:0]     cnt_q;

  // Line with the incoming beat dropped into the current slot
  always_comb begin
    fill_o = buf_q;
    fill_o[cnt_q*BEAT_BITS +: BEAT_BITS] = ins_data_i;
  end

  assign beat_o = buf_q[cnt_q*BEAT_BITS +: BEAT_BITS];
  assign last_o = (cnt_q == CNT_W'(BEATS-1));

  // Buffer load / beat insert / counter advance
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      buf_q <= load_data_i;
      cnt_q <= '0;
    end else if (ins_i) begin
      buf_q <= fill_o;
      cnt_q <= cnt_q + 1'b1;
    end else if (adv_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates the 64-bit bmem port between I$ and D$ line traffic.
// One transaction at a time, round-robin on ties.
module bmem_arbiter
  import bmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  arb_state_t state_q, state_d;
  arb_port_t  grant_q, grant_d;
  arb_port_t  last_q, last_d;
  logic       wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] i_rdata_q, d_rdata_q;

  logic                 load;
  logic [LINE_BITS-1:0] load_data;
  logic                 ins;
  logic                 adv;
  logic [LINE_BITS-1:0] asm_fill;
  logic [BEAT_BITS-1:0] asm_beat;
  logic                 asm_last;
  logic                 i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  line_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_data),
    .ins_i       (ins),
    .ins_data_i  (bmem_rdata),
    .adv_i       (adv),
    .fill_o      (asm_fill),
    .beat_o      (asm_beat),
    .last_o      (asm_last)
  );

  // Arbitration and transaction sequencing
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    load      = 1'b0;
    load_data = '0;
    ins       = 1'b0;
    adv       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req)
            grant_d = (last_q == PORT_I) ? PORT_D : PORT_I;
          else
            grant_d = d_req ? PORT_D : PORT_I;
          if (grant_d == PORT_D) begin
            addr_d = line_align(d_addr);
            wr_d   = d_write;
          end else begin
            addr_d = line_align(i_addr);
            wr_d   = 1'b0;
          end
          load      = 1'b1;
          load_data = wr_d ? d_wdata : '0;
          state_d   = wr_d ? ST_WR_BEAT : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (bmem_ready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (bmem_rvalid && bmem_raddr == addr_q) begin
          ins = 1'b1;
          if (asm_last) state_d = ST_RESP;
        end
      end
      ST_WR_BEAT: begin
        if (bmem_ready) begin
          adv = 1'b1;
          if (asm_last) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= PORT_I;
      last_q  <= PORT_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end

  // Fill lines land on the final beat so they are valid with resp
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (ins && asm_last) begin
      if (grant_q == PORT_I) i_rdata_q <= asm_fill;
      else                   d_rdata_q <= asm_fill;
    end
  end

  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_resp     = (state_q == ST_RESP) && (grant_q == PORT_I);
  assign d_resp     = (state_q == ST_RESP) && (grant_q == PORT_D);
  assign bmem_read  = (state_q == ST_RD_REQ);
  assign bmem_write = (state_q == ST_WR_BEAT);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? asm_beat : '0;

endmodule
